// File: rtl/riscv_tests_monitor.sv
// ============================================================================
// Module      : riscv_tests_monitor
// Description : Watches the mem(r)-stage jump stream and gp (x3) to report
//               riscv-tests pass/fail/timeout with saturating tallies.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_tests_monitor #(
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [DATA_WIDTH-1:0] END_PC         = 32'h0000_003C,
  parameter int                    SETTLE_CYCLES  = 10,
  parameter int                    TIMEOUT_CYCLES = 1000000,
  parameter int                    CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  clr_cnt,
  input  logic                  jmp_do,
  input  logic [DATA_WIDTH-1:0] jmp_pc,
  input  logic [DATA_WIDTH-1:0] gp_v,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [DATA_WIDTH-2:0] fail_id,
  output logic [CNT_WIDTH-1:0]  pass_cnt,
  output logic [CNT_WIDTH-1:0]  fail_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [TW-1:0] c_timer_last  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] c_settle_init = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_SETTLE = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_end_jump;
  logic                    w_arm;
  logic                    w_expire;
  logic                    w_sample;
  logic [TW-1:0]           r_timer;
  logic [SW-1:0]           r_settle;
  logic                    r_pass;
  logic                    r_timeout;
  logic [DATA_WIDTH-2:0]   r_fail_id;
  logic [CNT_WIDTH-1:0]    r_pass_cnt;
  logic [CNT_WIDTH-1:0]    r_fail_cnt;

  assign w_end_jump = jmp_do && (jmp_pc == END_PC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // START restarts a run from any state; it outranks jump and timeout.
  always_comb begin
    w_state_nxt = r_state;
    done        = 1'b0;
    w_arm       = 1'b0;
    w_expire    = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end else if (w_end_jump) begin
          w_state_nxt = S_SETTLE;
          w_arm       = 1'b1;
        end else if (r_timer == c_timer_last) begin
          w_state_nxt = S_REPORT;
          w_expire    = 1'b1;
        end
      end
      S_SETTLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end else if (r_settle == '0) begin
          w_state_nxt = S_REPORT;
          w_sample    = 1'b1;
        end
      end
      S_REPORT: begin
        done        = 1'b1;
        w_state_nxt = start ? S_RUN : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer    <= '0;
      r_settle   <= '0;
      r_pass     <= 1'b0;
      r_timeout  <= 1'b0;
      r_fail_id  <= '0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
    end else begin
      if (start) begin
        r_timer   <= '0;
        r_pass    <= 1'b0;
        r_timeout <= 1'b0;
        r_fail_id <= '0;
      end else begin
        if (r_state == S_RUN) r_timer <= r_timer + 1'b1;
        if (w_arm) begin
          r_settle <= c_settle_init;
        end else if (r_state == S_SETTLE && r_settle != '0) begin
          r_settle <= r_settle - 1'b1;
        end
        if (w_expire) begin
          r_timeout <= 1'b1;
          r_pass    <= 1'b0;
        end
        if (w_sample) begin
          r_pass    <= (gp_v == DATA_WIDTH'(1));
          r_fail_id <= (gp_v == DATA_WIDTH'(1)) ? '0 : gp_v[DATA_WIDTH-1:1];
        end
      end

      // An aborted report still pulses DONE but is not tallied.
      if (clr_cnt) begin
        r_pass_cnt <= '0;
        r_fail_cnt <= '0;
      end else if (r_state == S_REPORT && !start) begin
        if (r_pass) begin
          if (r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + 1'b1;
        end else begin
          if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + 1'b1;
        end
      end
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign pass     = r_pass;
  assign timeout  = r_timeout;
  assign fail_id  = r_fail_id;
  assign pass_cnt = r_pass_cnt;
  assign fail_cnt = r_fail_cnt;

endmodule

`default_nettype wire

// File: tb/tb_riscv_tests_monitor.sv
// ============================================================================
// Module      : tb_riscv_tests_monitor
// Description : Directed self-checking bench for riscv_tests_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_tests_monitor;

  localparam int          DW      = 32;
  localparam logic [31:0] c_end   = 32'h0000_003C;
  localparam int          c_set   = 10;
  localparam int          c_to    = 100;
  localparam int          c_cw    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          clr_cnt = 1'b0;
  logic          jmp_do = 1'b0;
  logic [DW-1:0] jmp_pc = '0;
  logic [DW-1:0] gp_v = '0;
  logic          busy;
  logic          done;
  logic          pass;
  logic          timeout;
  logic [DW-2:0] fail_id;
  logic [c_cw-1:0] pass_cnt;
  logic [c_cw-1:0] fail_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  int done_seen;

  riscv_tests_monitor #(
    .DATA_WIDTH    (DW),
    .END_PC        (c_end),
    .SETTLE_CYCLES (c_set),
    .TIMEOUT_CYCLES(c_to),
    .CNT_WIDTH     (c_cw)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .clr_cnt (clr_cnt),
    .jmp_do  (jmp_do),
    .jmp_pc  (jmp_pc),
    .gp_v    (gp_v),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .timeout (timeout),
    .fail_id (fail_id),
    .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until DONE is visible; cyc starts at first and counts cycles taken.
  task automatic wait_done(input int first, output int cyc);
    cyc = first;
    while (!done && cyc < 300) begin
      step();
      cyc++;
    end
    if (!done) check("done_wait", 32'd0, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Starts a run, idles pre cycles, issues the end jump and waits for DONE.
  task automatic run_jump(input logic [31:0] gp, input int pre, output int cyc);
    gp_v = gp;
    pulse_start();
    repeat (pre) step();
    jmp_do = 1'b1;
    jmp_pc = c_end;
    step();
    jmp_do = 1'b0;
    jmp_pc = '0;
    wait_done(1, cyc);
  endtask

  initial begin
    step();
    step();
    check("rst_busy",    {31'd0, busy},     32'd0);
    check("rst_done",    {31'd0, done},     32'd0);
    check("rst_pass",    {31'd0, pass},     32'd0);
    check("rst_timeout", {31'd0, timeout},  32'd0);
    check("rst_fail_id", {1'b0, fail_id},   32'd0);
    check("rst_pcnt",    {30'd0, pass_cnt}, 32'd0);
    check("rst_fcnt",    {30'd0, fail_cnt}, 32'd0);
    rst_n = 1'b1;
    step();

    // Pass: end-jump on the 50th RUN cycle
    run_jump(32'd1, 49, lat);
    check("t1_latency", lat, 32'd11);
    check("t1_pass",    {31'd0, pass}, 32'd1);
    check("t1_busy",    {31'd0, busy}, 32'd1);
    step();
    check("t1_idle",    {31'd0, busy},     32'd0);
    check("t1_done_lo", {31'd0, done},     32'd0);
    check("t1_pcnt",    {30'd0, pass_cnt}, 32'd1);
    check("t1_fcnt",    {30'd0, fail_cnt}, 32'd0);

    // Fail with gp = 7 -> test number 3
    run_jump(32'h0000_0007, 5, lat);
    check("t2_latency", lat, 32'd11);
    check("t2_pass",    {31'd0, pass},    32'd0);
    check("t2_fail_id", {1'b0, fail_id},  32'd3);
    check("t2_timeout", {31'd0, timeout}, 32'd0);
    step();
    check("t2_fcnt", {30'd0, fail_cnt}, 32'd1);
    check("t2_pcnt", {30'd0, pass_cnt}, 32'd1);

    // Timeout, no end jump
    gp_v = 32'd1;
    pulse_start();
    check("t3_cleared_fail_id", {1'b0, fail_id}, 32'd0);
    wait_done(0, lat);
    check("t3_latency", lat, 32'd100);
    check("t3_timeout", {31'd0, timeout}, 32'd1);
    check("t3_pass",    {31'd0, pass},    32'd0);
    step();
    check("t3_fcnt", {30'd0, fail_cnt}, 32'd2);

    // Non-matching jump must not arm SETTLE
    gp_v = 32'd1;
    pulse_start();
    jmp_do = 1'b1;
    jmp_pc = 32'h0000_0038;
    step();
    jmp_pc = c_end;
    step();
    jmp_do = 1'b0;
    wait_done(1, lat);
    check("t4_latency", lat, 32'd11);
    check("t4_pass",    {31'd0, pass}, 32'd1);
    step();

    // Match in the same cycle the timer expires -> pass path
    run_jump(32'd1, 99, lat);
    check("t4b_latency", lat, 32'd11);
    check("t4b_pass",    {31'd0, pass},    32'd1);
    check("t4b_timeout", {31'd0, timeout}, 32'd0);
    step();
    check("t4b_pcnt", {30'd0, pass_cnt}, 32'd3);

    // START during SETTLE aborts without DONE
    gp_v = 32'd1;
    pulse_start();
    jmp_do = 1'b1;
    jmp_pc = c_end;
    step();
    jmp_do = 1'b0;
    repeat (3) step();
    pulse_start();
    check("t5_busy", {31'd0, busy}, 32'd1);
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) done_seen++;
      step();
    end
    check("t5_no_done", done_seen, 32'd0);
    check("t5_pass_clr", {31'd0, pass}, 32'd0);

    // Asynchronous reset mid-RUN
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", {31'd0, busy},     32'd0);
    check("t5_rst_pcnt", {30'd0, pass_cnt}, 32'd0);
    check("t5_rst_fcnt", {30'd0, fail_cnt}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Saturation: five passes on a 2-bit tally
    for (int k = 0; k < 5; k++) begin
      run_jump(32'd1, 0, lat);
      step();
    end
    check("t6_sat", {30'd0, pass_cnt}, 32'd3);

    // CLR_CNT wins over the REPORT increment
    run_jump(32'd1, 0, lat);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    check("t6_clr", {30'd0, pass_cnt}, 32'd0);

    // START in REPORT: DONE pulses, no tally
    run_jump(32'd1, 0, lat);
    check("t6_abort_done", {31'd0, done}, 32'd1);
    pulse_start();
    check("t6_abort_pcnt", {30'd0, pass_cnt}, 32'd0);
    check("t6_abort_busy", {31'd0, busy},     32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
